// File: rtl/four_bit_divider_ctrl_pkg.sv
// Shared definitions for the four_bit_divider_ctrl slice.
//   state_t   : FSM state encodings (IDLE / RUN / DONE)
//   ITER_LAST : iteration count minus one, loaded into the counter on accept
//   DIV0_Q    : quotient reported for a divide-by-zero request
package four_bit_divider_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ITER_LAST = 2'd3;
    localparam logic [3:0] DIV0_Q    = 4'hF;

endpackage

// File: rtl/four_bit_divider_ctrl_subtractor.sv
// four_bit_subtractor: combinational 4-bit subtractor with borrow.
//   a, b : operands (unsigned)
//   c    : borrow in
//   diff : (a - b - c) mod 16
//   bo   : borrow out, high when a < b + c
module four_bit_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] diff,
    output logic       bo
);

    logic [4:0] full;

    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {4'b0000, c};
        diff = full[3:0];
        bo   = full[4];
    end

endmodule

// File: rtl/four_bit_divider_ctrl.sv
// four_bit_divider_ctrl: sequential restoring divider for 4-bit unsigned
// operands, one iteration per clock over four cycles using a single
// four_bit_subtractor.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, only looked at in IDLE
//   a, b       : dividend / divisor, captured on the accepting edge
//   q, r       : registered quotient / remainder
//   busy       : high whenever the FSM is not IDLE
//   done       : one-cycle completion pulse (DONE state)
//   err        : divide-by-zero flag of the last operation
module four_bit_divider_ctrl
    import four_bit_divider_ctrl_pkg::*;
#(
    // Only 4 is supported: the datapath is the fixed-width subtractor.
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder R
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend/quotient shift register Q
    logic [WIDTH-1:0] div_q, div_d;      // captured divisor D
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_bo;
    logic             ge;
    logic [WIDTH-1:0] new_r;
    logic [WIDTH-1:0] new_q;

    four_bit_subtractor u_sub (
        .a    (t[WIDTH-1:0]),
        .b    (div_q),
        .c    (1'b0),
        .diff (sub_diff),
        .bo   (sub_bo)
    );

    // When t[4] is set the true difference 16+t[3:0]-D is below 16,
    // so the wrapped 4-bit diff is already the exact new remainder.
    always_comb begin
        t     = {rem_q, quo_q[WIDTH-1]};
        ge    = t[WIDTH] | ~sub_bo;
        new_r = ge ? sub_diff : t[WIDTH-1:0];
        new_q = {quo_q[WIDTH-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (b != '0) begin
                        rem_d   = '0;
                        quo_d   = a;
                        div_d   = b;
                        cnt_d   = ITER_LAST;
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        q_out_d = DIV0_Q;
                        r_out_d = a;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                rem_d = new_r;
                quo_d = new_q;
                if (cnt_q == 2'd0) begin
                    q_out_d = new_q;
                    r_out_d = new_r;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Status flags are registered copies of the next-state decode.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_out_q;
    assign r    = r_out_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_four_bit_divider_ctrl.sv
// Directed and exhaustive bench for four_bit_divider_ctrl.
module tb_four_bit_divider_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       err;

    int n_vec  = 0;
    int n_miss = 0;

    four_bit_divider_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       err;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request (start for a single cycle), scramble the operand
    // inputs afterwards, and check latency, results and the done width.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic eerr, input int elat);
        int lat;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(negedge clk);
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        chk("busy_after_accept", int'(busy), 1);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency %0d/%0d", ta, tb), lat, elat);
        chk($sformatf("q %0d/%0d", ta, tb), int'(q), int'(eq));
        chk($sformatf("r %0d/%0d", ta, tb), int'(r), int'(er));
        chk($sformatf("err %0d/%0d", ta, tb), int'(err), int'(eerr));
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    vec_t vt[9];
    logic [3:0] hq[3];
    logic [3:0] hr[3];
    logic [3:0] ha[3];
    logic [3:0] hb[3];
    logic       seen_done;

    initial begin
        vt[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, err: 1'b0, lat: 5};
        vt[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, err: 1'b0, lat: 5};
        vt[2] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, err: 1'b0, lat: 5};
        vt[3] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7, err: 1'b0, lat: 5};
        vt[4] = '{a: 4'd14, b: 4'd2,  q: 4'd7,  r: 4'd0, err: 1'b0, lat: 5};
        vt[5] = '{a: 4'd9,  b: 4'd0,  q: 4'hF,  r: 4'd9, err: 1'b1, lat: 1};
        vt[6] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, err: 1'b0, lat: 5};
        vt[7] = '{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1, err: 1'b0, lat: 5};
        vt[8] = '{a: 4'd11, b: 4'd4,  q: 4'd2,  r: 4'd3, err: 1'b0, lat: 5};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_q", int'(q), 0);
        chk("reset_r", int'(r), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            do_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].err, vt[i].lat);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_reset_q", int'(q), 0);
        chk("midrun_reset_r", int'(r), 0);
        chk("midrun_reset_err", int'(err), 0);
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_done", int'(done), 0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("no_activity_after_reset", int'(seen_done), 0);

        // start held high: new operands only at accepting edges, every 6 cycles.
        ha[0] = 4'd13; hb[0] = 4'd3; hq[0] = 4'd4; hr[0] = 4'd1;
        ha[1] = 4'd14; hb[1] = 4'd2; hq[1] = 4'd7; hr[1] = 4'd0;
        ha[2] = 4'd15; hb[2] = 4'd4; hq[2] = 4'd3; hr[2] = 4'd3;
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("hs_busy k=%0d", k), int'(busy), (k % 6 != 0) ? 1 : 0);
                chk($sformatf("hs_done k=%0d", k), int'(done), (k % 6 == 5) ? 1 : 0);
                if (k % 6 == 5) begin
                    chk($sformatf("hs_q op%0d", k / 6), int'(q), int'(hq[k / 6]));
                    chk($sformatf("hs_r op%0d", k / 6), int'(r), int'(hr[k / 6]));
                    chk($sformatf("hs_err op%0d", k / 6), int'(err), 0);
                end
            end
            if (k == 18) begin
                start = 1'b0;
            end else begin
                start = 1'b1;
                if (k % 6 == 0) begin
                    a = ha[k / 6];
                    b = hb[k / 6];
                end else begin
                    a = 4'($urandom);
                    b = 4'($urandom);
                end
            end
        end
        @(negedge clk);
        chk("hs_idle_after", int'(busy), 0);

        // Every operand pair against a reference model.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                if (ib == 0)
                    do_op(4'(ia), 4'(ib), 4'hF, 4'(ia), 1'b1, 1);
                else
                    do_op(4'(ia), 4'(ib), 4'(ia / ib), 4'(ia % ib), 1'b0, 5);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
